// File: rtl/shuffle_controller_if.sv
// Job/result handshake bundle for shuffle_controller: start/ready in, valid/ready out.
interface shuffle_controller_if #(
  parameter int N      = 10,
  parameter int ROUNDS = 8
);
  localparam int RW = $clog2(ROUNDS + 1);

  logic          start_i;
  logic [N-1:0]  x_i;
  logic          ready_o;
  logic          busy_o;
  logic [RW-1:0] round_o;
  logic [N-1:0]  x_o;
  logic          valid_o;
  logic          ready_i;

  modport master (
    output start_i, x_i, ready_i,
    input  ready_o, busy_o, round_o, x_o, valid_o
  );

  modport slave (
    input  start_i, x_i, ready_i,
    output ready_o, busy_o, round_o, x_o, valid_o
  );
endinterface

// File: rtl/shuffle_controller.sv
// Multi-round odd-even transposition shuffler driven by a 16-bit Fibonacci LFSR.
// Optional runtime seed loading in IDLE: define SHUFFLE_CTRL_SEED_LOAD_EN.
module shuffle_controller #(
  parameter int                N      = 10,
  parameter int                ROUNDS = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic clk,
  input  logic reset_n,
`ifdef SHUFFLE_CTRL_SEED_LOAD_EN
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              seed_load_i,
`endif
  shuffle_controller_if.slave bus
);

  localparam int RW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [N-1:0]      r_work;
  logic [N-1:0]      r_xo;
  logic [RW-1:0]     r_round;
  logic [LFSR_W-1:0] r_lfsr;
  logic [N-1:0]      w_work_next;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic              w_last_round;

  assign w_lfsr_next  = {r_lfsr[LFSR_W-2:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_last_round = (r_round == RW'(ROUNDS - 1));

  // One transposition stage; pair k is gated by lfsr bit k, phase chosen by round parity.
  always_comb begin
    w_work_next = r_work;
    if (!r_round[0]) begin
      for (int unsigned k = 0; k < N / 2; k++) begin
        if (r_lfsr[k]) begin
          w_work_next[2*k]   = r_work[2*k+1];
          w_work_next[2*k+1] = r_work[2*k];
        end
      end
    end else begin
      for (int unsigned k = 0; k < (N - 1) / 2; k++) begin
        if (r_lfsr[k]) begin
          w_work_next[2*k+1] = r_work[2*k+2];
          w_work_next[2*k+2] = r_work[2*k+1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start_i)  w_state_next = S_RUN;
      S_RUN:   if (w_last_round) w_state_next = S_DONE;
      S_DONE:  if (bus.ready_i)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = (r_state == S_IDLE);
    bus.busy_o  = (r_state == S_RUN);
    bus.valid_o = (r_state == S_DONE);
    bus.round_o = r_round;
    bus.x_o     = r_xo;
  end

  // Result is captured into its own register so x_o ignores work activity outside DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work  <= '0;
      r_xo    <= '0;
      r_round <= '0;
      r_lfsr  <= SEED;
    end else begin
      unique case (r_state)
        S_IDLE: begin
`ifdef SHUFFLE_CTRL_SEED_LOAD_EN
          if (seed_load_i) r_lfsr <= (seed_i == '0) ? SEED : seed_i;
`endif
          if (bus.start_i) begin
            r_work  <= bus.x_i;
            r_round <= '0;
          end
        end
        S_RUN: begin
          r_work  <= w_work_next;
          r_lfsr  <= w_lfsr_next;
          r_round <= r_round + RW'(1);
          if (w_last_round) r_xo <= w_work_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shuffle_controller.sv
// Directed self-checking bench for shuffle_controller (default and single-round/seed-1 builds).
module tb_shuffle_controller;
  localparam int N      = 10;
  localparam int ROUNDS = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shuffle_controller_if #(.N(N), .ROUNDS(ROUNDS)) bus ();
  shuffle_controller_if #(.N(N), .ROUNDS(1))      bus1 ();

`ifdef SHUFFLE_CTRL_SEED_LOAD_EN
  logic [15:0] seed_tie = '0;
  logic        seed_ld  = 1'b0;
`endif

  shuffle_controller #(.N(N), .ROUNDS(ROUNDS), .LFSR_W(16), .SEED(16'hACE1)) u_dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SHUFFLE_CTRL_SEED_LOAD_EN
    .seed_i(seed_tie), .seed_load_i(seed_ld),
`endif
    .bus(bus)
  );

  shuffle_controller #(.N(N), .ROUNDS(1), .LFSR_W(16), .SEED(16'h0001)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
`ifdef SHUFFLE_CTRL_SEED_LOAD_EN
    .seed_i(seed_tie), .seed_load_i(seed_ld),
`endif
    .bus(bus1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_lfsr;
  logic [9:0]  first_result;

  function automatic logic [15:0] m_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] m_adv(input logic [15:0] l, input int n);
    logic [15:0] v;
    v = l;
    for (int i = 0; i < n; i++) v = m_step(v);
    return v;
  endfunction

  function automatic logic [9:0] m_job(input logic [9:0] x, input logic [15:0] seed, input int rounds);
    logic [9:0]  v;
    logic [15:0] l;
    logic        t;
    v = x;
    l = seed;
    for (int r = 0; r < rounds; r++) begin
      for (int lo = r % 2; lo + 1 < 10; lo += 2) begin
        if (l[(lo - r % 2) / 2]) begin
          t       = v[lo];
          v[lo]   = v[lo+1];
          v[lo+1] = t;
        end
      end
      l = m_step(l);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [9:0] x);
    @(negedge clk);
    bus.x_i     = x;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.start_i  = 1'b0; bus.x_i  = '0; bus.ready_i  = 1'b0;
    bus1.start_i = 1'b0; bus1.x_i = '0; bus1.ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o} !== {3'b100, 4'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy/busy/vld=%b%b%b round=%0d x_o=%h, required 100 0 000",
               bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_lfsr  = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o} !== {3'b100, 4'd0, 10'd0}) begin
        n_fail++;
        $display("FAIL idle_quiet cyc %0d: rdy/busy/vld=%b%b%b round=%0d x_o=%h, required 100 0 000",
                 i, bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o);
      end
    end
  endtask

  task automatic test_single_round();
    @(negedge clk);
    bus1.x_i     = 10'h001;
    bus1.start_i = 1'b1;
    tick();
    bus1.start_i = 1'b0;
    n_checks++;
    if ({bus1.busy_o, bus1.valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_accept: busy/vld=%b%b, required 10", bus1.busy_o, bus1.valid_o);
    end
    tick();
    n_checks++;
    if ({bus1.valid_o, bus1.x_o, bus1.round_o} !== {1'b1, 10'h002, 1'b1}) begin
      n_fail++;
      $display("FAIL single_result: vld=%b x_o=%h round=%0d, required 1 002 1",
               bus1.valid_o, bus1.x_o, bus1.round_o);
    end
    @(negedge clk);
    bus1.ready_i = 1'b1;
    tick();
    bus1.ready_i = 1'b0;
    n_checks++;
    if ({bus1.ready_o, bus1.valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_release: rdy/vld=%b%b, required 10", bus1.ready_o, bus1.valid_o);
    end
  endtask

  task automatic test_full_job();
    logic [9:0] exp;
    bus.ready_i = 1'b1;
    start_job(10'h3A5);
    exp    = m_job(10'h3A5, m_lfsr, ROUNDS);
    m_lfsr = m_adv(m_lfsr, ROUNDS);
    first_result = exp;
    n_checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o} !== {3'b010, 4'd0}) begin
      n_fail++;
      $display("FAIL full_accept: rdy/busy/vld=%b%b%b round=%0d, required 010 0",
               bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o);
    end
    for (int r = 1; r < ROUNDS; r++) begin
      tick();
      n_checks++;
      if ({bus.busy_o, bus.valid_o, bus.round_o} !== {2'b10, 4'(r)}) begin
        n_fail++;
        $display("FAIL full_round %0d: busy/vld=%b%b round=%0d, required 10 %0d",
                 r, bus.busy_o, bus.valid_o, bus.round_o, r);
      end
    end
    tick();
    n_checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o} !== {3'b001, 4'd8, exp}) begin
      n_fail++;
      $display("FAIL full_done: rdy/busy/vld=%b%b%b round=%0d x_o=%h, required 001 8 %h",
               bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o, exp);
    end
    n_checks++;
    if ($countones(bus.x_o) !== 6) begin
      n_fail++;
      $display("FAIL full_popcount: got %0d, required 6", $countones(bus.x_o));
    end
    tick();
    n_checks++;
    if ({bus.ready_o, bus.valid_o, bus.x_o} !== {2'b10, exp}) begin
      n_fail++;
      $display("FAIL full_release: rdy/vld=%b%b x_o=%h, required 10 %h",
               bus.ready_o, bus.valid_o, bus.x_o, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    bus.ready_i = 1'b0;
    start_job(10'h155);
    exp    = m_job(10'h155, m_lfsr, ROUNDS);
    m_lfsr = m_adv(m_lfsr, ROUNDS);
    repeat (ROUNDS) tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.valid_o, bus.ready_o, bus.x_o} !== {2'b10, exp}) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: vld/rdy=%b%b x_o=%h, required 10 %h",
                 i, bus.valid_o, bus.ready_o, bus.x_o, exp);
      end
      tick();
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    tick();
    n_checks++;
    if ({bus.ready_o, bus.valid_o, bus.x_o} !== {2'b10, exp}) begin
      n_fail++;
      $display("FAIL bp_release: rdy/vld=%b%b x_o=%h, required 10 %h",
               bus.ready_o, bus.valid_o, bus.x_o, exp);
    end
  endtask

  task automatic test_ignored_start();
    logic [9:0] exp;
    bus.ready_i = 1'b1;
    start_job(10'h0F0);
    exp    = m_job(10'h0F0, m_lfsr, ROUNDS);
    m_lfsr = m_adv(m_lfsr, ROUNDS);
    repeat (3) tick();
    bus.x_i     = 10'h3FF;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_early: vld=%b at round 7, required 0", bus.valid_o);
    end
    tick();
    n_checks++;
    if ({bus.valid_o, bus.x_o} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL ign_result: vld=%b x_o=%h, required 1 %h", bus.valid_o, bus.x_o, exp);
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if ({bus.ready_o, bus.busy_o, bus.valid_o} !== 3'b100) begin
        n_fail++;
        $display("FAIL ign_no_second cyc %0d: rdy/busy/vld=%b%b%b, required 100",
                 i, bus.ready_o, bus.busy_o, bus.valid_o);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp1, exp2;
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.x_i     = 10'h2C3;
    bus.start_i = 1'b1;
    tick();
    exp1   = m_job(10'h2C3, m_lfsr, ROUNDS);
    m_lfsr = m_adv(m_lfsr, ROUNDS);
    repeat (ROUNDS) tick();
    n_checks++;
    if ({bus.valid_o, bus.x_o} !== {1'b1, exp1}) begin
      n_fail++;
      $display("FAIL b2b_first: vld=%b x_o=%h, required 1 %h", bus.valid_o, bus.x_o, exp1);
    end
    tick();
    n_checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_handshake_start: rdy/busy/vld=%b%b%b, required 100",
               bus.ready_o, bus.busy_o, bus.valid_o);
    end
    bus.x_i = 10'h1E1;
    tick();
    bus.start_i = 1'b0;
    exp2   = m_job(10'h1E1, m_lfsr, ROUNDS);
    m_lfsr = m_adv(m_lfsr, ROUNDS);
    n_checks++;
    if ({bus.busy_o, bus.round_o} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_second_accept: busy=%b round=%0d, required 1 0", bus.busy_o, bus.round_o);
    end
    repeat (ROUNDS) tick();
    n_checks++;
    if ({bus.valid_o, bus.x_o} !== {1'b1, exp2}) begin
      n_fail++;
      $display("FAIL b2b_second: vld=%b x_o=%h, required 1 %h", bus.valid_o, bus.x_o, exp2);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    bus.ready_i = 1'b1;
    start_job(10'h3A5);
    repeat (3) tick();
    n_checks++;
    if (bus.round_o !== 4'd3) begin
      n_fail++;
      $display("FAIL mr_round: round=%0d, required 3", bus.round_o);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o} !== {3'b100, 4'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL mr_async: rdy/busy/vld=%b%b%b round=%0d x_o=%h, required 100 0 000",
               bus.ready_o, bus.busy_o, bus.valid_o, bus.round_o, bus.x_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_lfsr  = 16'hACE1;
    start_job(10'h3A5);
    m_lfsr = m_adv(m_lfsr, ROUNDS);
    repeat (ROUNDS) tick();
    n_checks++;
    if ({bus.valid_o, bus.x_o} !== {1'b1, first_result}) begin
      n_fail++;
      $display("FAIL mr_repeat: vld=%b x_o=%h, required 1 %h", bus.valid_o, bus.x_o, first_result);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_full_job();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shuffle_controller.md
Name: shuffle_controller

Overview:
- Sequences a pairwise bit-swap datapath over multiple rounds to produce a randomly permuted N-bit vector for fault-injection and redundancy simulations.
- Each round applies an odd-even transposition stage with swap decisions from an internal LFSR.
- Input side is a start/ready handshake; output side is a valid/ready handshake.
- Sits between the stimulus source and the reliability-evaluation logic.

Parameters:
- N, 10, vector width; N >= 2.
- ROUNDS, 8, swap rounds per job; ROUNDS >= 1.
- LFSR_W, 16, LFSR width; fixed at 16; floor(N/2) <= LFSR_W.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_i  input  1  job request; accepted only when ready_o=1.
- x_i  input  N  vector to shuffle; sampled on the accepting edge.
- ready_o  output  1  controller idle, can accept a job.
- busy_o  output  1  rounds in progress.
- round_o  output  $clog2(ROUNDS+1)  completed rounds of the current job.
- x_o  output  N  shuffled result; valid when valid_o=1.
- valid_o  output  1  result available.
- ready_i  input  1  downstream accepts result.

Behaviour:
- Reset (async assert, sync deassert by the flops): state=IDLE, x_o=0, valid_o=0, busy_o=0, ready_o=1, round_o=0, lfsr=SEED. Reset mid-job aborts the job with no output.
- State IDLE: ready_o=1.
  - start_i=1 at a rising edge loads work<=x_i and round<=0, then goes to RUN.
  - start_i=0: stay in IDLE.
- State RUN: busy_o=1, ready_o=0. Each edge applies one round to work, advances the lfsr one step, and increments round.
  - Phase = round[0]. Even phase (0) pairs bits (0,1),(2,3),... Odd phase (1) pairs bits (1,2),(3,4),...
  - Unpaired bits pass through unchanged: the top bit when N is odd in even phase; bit 0 and the top bit when N is even in odd phase.
  - Pair k uses mask bit lfsr[k], taken from the lfsr value before this edge's advance. Mask bit 1 swaps the pair; 0 keeps it.
  - On the edge completing round ROUNDS-1, go to DONE.
- LFSR: Fibonacci, shift left, bit0_new = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]. It advances only in RUN and is not reseeded between jobs.
- State DONE: valid_o=1, x_o=work held stable, round_o=ROUNDS, busy_o=0, ready_o=0.
  - valid_o & ready_i at an edge: go to IDLE, valid_o<=0. x_o holds its last value.
- Latency: start accepted at edge E0 gives valid_o=1 after edge E0+ROUNDS.
- Throughput: one job per ROUNDS+2 cycles with ready_i tied high.
- start_i while not ready_o is ignored, not queued.
- start_i in the same cycle as the DONE handshake is ignored; IDLE is entered first.
- Permutation only: popcount(x_o) == popcount(x_i) for every job.

Optional Feature:
- Macro SHUFFLE_CTRL_SEED_LOAD_EN.
- With the macro defined:
  - Adds ports seed_i (input, 16) and seed_load_i (input, 1).
  - In IDLE, seed_load_i=1 loads lfsr<=seed_i, or SEED if seed_i==0.
  - If seed_load_i and start_i are high together, the seed loads first and the job starts in the same edge; round 0 uses the new seed.
  - seed_load_i is ignored outside IDLE.
- Without the macro: neither port exists, and the lfsr is set only by reset.

Test Plan:
- Reset then idle: hold reset_n=0, then release -> ready_o=1, valid_o=0, x_o=0, round_o=0, with no activity for 20 cycles while start_i=0.
- Single round: SEED=16'h0001, ROUNDS=1, N=10, x_i=10'h001, start pulse -> valid_o=1 exactly 1 edge after accept, x_o=10'h002 (pair 0 swapped, all other masks 0).
- Full job: ROUNDS=8, x_i=10'h3A5, ready_i=1 -> valid_o=1 after 8 RUN edges, popcount(x_o)=6, round_o=8, busy_o=0. x_o must match a reference-model LFSR and shuffle.
- Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o and x_o stable. ready_i=1 -> IDLE next edge, ready_o=1.
- Ignored start: pulse start_i with x_i=10'h3FF during RUN -> the current job's result is unaffected, and no second job runs.
- Mid-job reset: assert reset_n=0 at round 3 -> outputs return to reset values asynchronously. After release, the lfsr restarts from SEED: a repeated job with the same x_i gives the same x_o as the first job after power-on.
